// File: rtl/tdc_pulse_gen_pkg.sv
// Shared types and default sizing for the tdc start/stop stimulus generator.
package tdc_pkg;

    // Sequencer states: waiting for a configuration, emitting a pair, idling between pairs.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLDOFF = 2'd2
    } tdc_state_e;

    localparam int DEF_DELAY_W = 8;
    localparam int DEF_WIDTH_W = 4;
    localparam int DEF_COUNT_W = 8;
    localparam int DEF_HOLDOFF = 16;

endpackage

// File: rtl/tdc_pulse_gen_window.sv
// Registered pulse window: output is high on the edge after t lies in [lo, lo+width).
// The comparison is widened by one bit so lo+width never wraps.
module tdc_pulse_window
    import tdc_pkg::*;
#(
    parameter int T_W     = DEF_DELAY_W + 1,
    parameter int WIDTH_W = DEF_WIDTH_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [T_W-1:0]     t_i,
    input  logic [T_W-1:0]     lo_i,
    input  logic [WIDTH_W-1:0] width_i,
    output logic               hit_o
);

    localparam int HI_W = T_W + 1;

    logic [HI_W-1:0] hi_s;
    logic            hit_d;
    logic            hit_q;

    assign hi_s = {1'b0, lo_i} + HI_W'(width_i);

    // Decide whether the current timeline position falls inside the window.
    always_comb begin
        hit_d = 1'b0;
        if (en_i && (t_i >= lo_i) && ({1'b0, t_i} < hi_s)) begin
            hit_d = 1'b1;
        end else begin
            hit_d = 1'b0;
        end
    end

    // Register the window result so the tdc sees a clean, glitch-free edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/tdc_pulse_gen.sv
// Start/stop pair generator for tdc calibration: programmable interval, pulse
// width, pair count (0 = free-running) and a fixed idle gap between pairs.
module tdc_pulse_gen
    import tdc_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int WIDTH_W = DEF_WIDTH_W,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic               abort,
    output logic               start_o,
    output logic               stop_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [COUNT_W-1:0] meas_cnt_o
);

    localparam int T_W  = DELAY_W + 1;
    localparam int HO_W = $clog2(HOLDOFF + 1);

    tdc_state_e         state_q;
    logic [T_W-1:0]     t_q;
    logic [HO_W-1:0]    hcnt_q;
    logic [COUNT_W-1:0] meas_q;
    logic [DELAY_W-1:0] delay_q;
    logic [WIDTH_W-1:0] width_q;
    logic [COUNT_W-1:0] count_q;
    logic               done_q;
    logic               ready_q;
    logic               busy_q;

    logic [WIDTH_W-1:0] width_eff_s;
    logic [T_W-1:0]     run_end_s;
    logic [T_W-1:0]     stop_lo_s;
    logic               win_en_s;

    assign width_eff_s = (cfg_width == {WIDTH_W{1'b0}}) ? WIDTH_W'(1) : cfg_width;
    assign run_end_s   = T_W'(delay_q) + T_W'(width_q) - T_W'(1);
    assign stop_lo_s   = T_W'(delay_q);

    // Windows only fire while a pair is in flight; abort forces both low on the next edge.
    always_comb begin
        win_en_s = 1'b0;
        if ((state_q == ST_RUN) && !abort) begin
            win_en_s = 1'b1;
        end else begin
            win_en_s = 1'b0;
        end
    end

    // Sequencer: handshake, pair timeline, holdoff gap, pair counting and completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= {T_W{1'b0}};
            hcnt_q  <= {HO_W{1'b0}};
            meas_q  <= {COUNT_W{1'b0}};
            delay_q <= {DELAY_W{1'b0}};
            width_q <= WIDTH_W'(1);
            count_q <= {COUNT_W{1'b0}};
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid && ready_q) begin
                        delay_q <= cfg_delay;
                        width_q <= width_eff_s;
                        count_q <= cfg_count;
                        meas_q  <= {COUNT_W{1'b0}};
                        t_q     <= {T_W{1'b0}};
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (t_q == run_end_s) begin
                        state_q <= ST_HOLDOFF;
                        hcnt_q  <= {HO_W{1'b0}};
                        meas_q  <= meas_q + COUNT_W'(1);
                        t_q     <= {T_W{1'b0}};
                    end else begin
                        t_q <= t_q + T_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (hcnt_q == HO_W'(HOLDOFF - 1)) begin
                        if ((count_q == {COUNT_W{1'b0}}) || (meas_q != count_q)) begin
                            state_q <= ST_RUN;
                            t_q     <= {T_W{1'b0}};
                        end else begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + HO_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    tdc_pulse_window #(
        .T_W     (T_W),
        .WIDTH_W (WIDTH_W)
    ) u_start_win (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (win_en_s),
        .t_i     (t_q),
        .lo_i    ({T_W{1'b0}}),
        .width_i (width_q),
        .hit_o   (start_o)
    );

    tdc_pulse_window #(
        .T_W     (T_W),
        .WIDTH_W (WIDTH_W)
    ) u_stop_win (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (win_en_s),
        .t_i     (t_q),
        .lo_i    (stop_lo_s),
        .width_i (width_q),
        .hit_o   (stop_o)
    );

    assign cfg_ready  = ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign meas_cnt_o = meas_q;

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Self-checking bench for tdc_pulse_gen: table-driven sequences, random
// configurations and hand-written reset corner cases against a timeline model.
module tb_tdc_pulse_gen;

    localparam int HO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_delay;
    logic [3:0] cfg_width;
    logic [7:0] cfg_count;
    logic       abort;
    logic       start_o;
    logic       stop_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] meas_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdc_pulse_gen #(
        .DELAY_W (8),
        .WIDTH_W (4),
        .COUNT_W (8),
        .HOLDOFF (HO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_count  (cfg_count),
        .abort      (abort),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .meas_cnt_o (meas_cnt_o)
    );

    typedef struct {
        int start;
        int stop;
        int busy;
        int done;
        int ready;
        int meas;
    } exp_t;

    typedef struct {
        int d;
        int w;
        int c;
        int abort_at;
        int ncyc;
        int exp_meas;
        int exp_dones;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pairs finished n edges after the accept edge (pair p leaves RUN at edge p*P+D+W).
    function automatic int pairs_done(input int n, input int d, input int w, input int c);
        int p;
        int m;
        p = d + w + HO;
        m = (n >= d + w) ? ((n - d - w) / p + 1) : 0;
        if (c != 0 && m > c) m = c;
        return m;
    endfunction

    // Expected outputs n edges after accept; w is the effective width (>= 1).
    function automatic exp_t exp_at(input int n, input int d, input int w, input int c,
                                    input int abort_at);
        exp_t e;
        int   p;
        int   pair;
        int   ph;
        int   active;
        p = d + w + HO;
        if (abort_at > 0 && n >= abort_at) begin
            e.start = 0; e.stop = 0; e.busy = 0; e.done = 0; e.ready = 1;
            e.meas  = pairs_done(abort_at - 1, d, w, c) % 256;
        end else begin
            e.busy  = (c == 0 || n < c * p) ? 1 : 0;
            e.ready = 1 - e.busy;
            e.done  = (c != 0 && n == c * p) ? 1 : 0;
            e.meas  = pairs_done(n, d, w, c) % 256;
            if (n >= 1) begin
                pair   = (n - 1) / p;
                ph     = (n - 1) % p;
                active = (c == 0 || pair < c) ? 1 : 0;
                e.start = (active != 0 && ph < w) ? 1 : 0;
                e.stop  = (active != 0 && ph >= d && ph < d + w) ? 1 : 0;
            end else begin
                e.start = 0;
                e.stop  = 0;
            end
        end
        return e;
    endfunction

    task automatic run_seq(input int d, input int w, input int c, input int abort_at,
                           input int ncyc, output int dones, output int meas_last);
        int   we;
        exp_t e;
        exp_t prev;
        we    = (w == 0) ? 1 : w;
        dones = 0;
        chk("ready_before_accept", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_delay = 8'(d);
        cfg_width = 4'(w);
        cfg_count = 8'(c);
        abort     = 1'($urandom_range(0, 1));
        tick();
        cfg_valid = 1'b0;
        abort     = 1'b0;
        chk("accept_busy", int'(busy_o), 1);
        chk("accept_ready", int'(cfg_ready), 0);
        chk("accept_meas", int'(meas_cnt_o), 0);
        chk("accept_start", int'(start_o), 0);
        for (int n = 1; n <= ncyc; n++) begin
            prev = exp_at(n - 1, d, we, c, abort_at);
            if (prev.busy != 0) begin
                abort     = (n == abort_at) ? 1'b1 : 1'b0;
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_delay = 8'($urandom_range(0, 255));
                cfg_width = 4'($urandom_range(0, 15));
                cfg_count = 8'($urandom_range(0, 255));
            end else begin
                abort     = 1'($urandom_range(0, 1));
                cfg_valid = 1'b0;
            end
            tick();
            e = exp_at(n, d, we, c, abort_at);
            chk("start_o", int'(start_o), e.start);
            chk("stop_o", int'(stop_o), e.stop);
            chk("busy_o", int'(busy_o), e.busy);
            chk("done_o", int'(done_o), e.done);
            chk("cfg_ready", int'(cfg_ready), e.ready);
            chk("meas_cnt_o", int'(meas_cnt_o), e.meas);
            dones += int'(done_o);
        end
        cfg_valid = 1'b0;
        abort     = 1'b0;
        meas_last = int'(meas_cnt_o);
    endtask

    vec_t tbl[8];

    initial begin
        int dones;
        int meas_last;
        int d;
        int w;
        int c;
        int p;
        int ab;

        tbl[0] = '{d: 5,   w: 2,  c: 1, abort_at: 0,    ncyc: 40,   exp_meas: 1, exp_dones: 1};
        tbl[1] = '{d: 0,   w: 3,  c: 1, abort_at: 0,    ncyc: 30,   exp_meas: 1, exp_dones: 1};
        tbl[2] = '{d: 7,   w: 0,  c: 2, abort_at: 0,    ncyc: 60,   exp_meas: 2, exp_dones: 1};
        tbl[3] = '{d: 10,  w: 1,  c: 4, abort_at: 0,    ncyc: 120,  exp_meas: 4, exp_dones: 1};
        tbl[4] = '{d: 4,   w: 3,  c: 0, abort_at: 30,   ncyc: 40,   exp_meas: 1, exp_dones: 0};
        tbl[5] = '{d: 2,   w: 5,  c: 3, abort_at: 0,    ncyc: 80,   exp_meas: 3, exp_dones: 1};
        tbl[6] = '{d: 255, w: 15, c: 1, abort_at: 0,    ncyc: 300,  exp_meas: 1, exp_dones: 1};
        tbl[7] = '{d: 0,   w: 1,  c: 0, abort_at: 4360, ncyc: 4370, exp_meas: 1, exp_dones: 0};

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_delay = 8'd0;
        cfg_width = 4'd0;
        cfg_count = 8'd0;
        abort     = 1'b0;

        // Power-on reset: three edges low, everything cleared, ready only after release.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", int'(cfg_ready), 0);
        end
        chk("rst_start", int'(start_o), 0);
        chk("rst_stop", int'(stop_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_meas", int'(meas_cnt_o), 0);
        rst_n = 1'b1;
        chk("ready_before_release_edge", int'(cfg_ready), 0);
        tick();
        chk("ready_after_release", int'(cfg_ready), 1);
        tick();

        // Directed table of sequences, each also checked cycle by cycle.
        for (int i = 0; i < 8; i++) begin
            run_seq(tbl[i].d, tbl[i].w, tbl[i].c, tbl[i].abort_at, tbl[i].ncyc,
                    dones, meas_last);
            chk($sformatf("vec%0d_final_meas", i), meas_last, tbl[i].exp_meas);
            chk($sformatf("vec%0d_done_count", i), dones, tbl[i].exp_dones);
        end

        // Random configurations, optional abort, all checked against the model.
        for (int i = 0; i < 10; i++) begin
            d = $urandom_range(0, 40);
            w = $urandom_range(0, 15);
            c = $urandom_range(0, 3);
            p = d + ((w == 0) ? 1 : w) + HO;
            ab = 0;
            if (c == 0 || $urandom_range(0, 2) == 0) begin
                ab = $urandom_range(1, (c == 0) ? 100 : c * p);
            end
            run_seq(d, w, c, ab, ((ab != 0) ? ab : c * p) + 8, dones, meas_last);
        end

        // Reset mid-run, during the holdoff after pair 2 (pair 2 completes at edge 38).
        chk("mid_ready_before", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_delay = 8'd10;
        cfg_width = 4'd1;
        cfg_count = 8'd4;
        tick();
        cfg_valid = 1'b0;
        for (int n = 1; n <= 44; n++) tick();
        chk("mid_meas_before_rst", int'(meas_cnt_o), 2);
        chk("mid_busy_before_rst", int'(busy_o), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_start", int'(start_o), 0);
        chk("mid_rst_stop", int'(stop_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_done", int'(done_o), 0);
        chk("mid_rst_meas", int'(meas_cnt_o), 0);
        chk("mid_rst_ready", int'(cfg_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_ready_after_release", int'(cfg_ready), 1);
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("mid_idle_start", int'(start_o), 0);
            chk("mid_idle_busy", int'(busy_o), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_pulse_gen.md
Name: tdc_pulse_gen

Overview:
- Clocked stimulus generator that drives the start/stop pair of the time-to-digital converter.
- Produces start/stop edges separated by a programmed, cycle-exact interval, repeated N times or free-running, with a holdoff between pairs.
- Sits between the configuration/control logic and the tdc inputs, so known intervals can be measured for calibration and self-test.
- Outputs are registered and glitch-free, because the tdc is edge-sensitive on both inputs.

Parameters:
- DELAY_W, 8, width of cfg_delay (start-rise to stop-rise interval in clk cycles).
- WIDTH_W, 4, width of cfg_width (high time of each pulse in cycles). Legal only if WIDTH_W <= DELAY_W.
- COUNT_W, 8, width of cfg_count and meas_cnt_o.
- HOLDOFF, 16, idle cycles (both outputs low) between consecutive pairs; must be >= 1.

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, synchronous active-low reset.
- cfg_valid, input, 1, configuration offered.
- cfg_ready, output, 1, high only in IDLE and not in reset.
- cfg_delay, input, DELAY_W, stop-rise minus start-rise, in cycles; 0 is legal.
- cfg_width, input, WIDTH_W, pulse high time; 0 is treated as 1.
- cfg_count, input, COUNT_W, number of pairs; 0 means free-running.
- abort, input, 1, synchronous stop request.
- start_o, output, 1, registered start pulse to the tdc.
- stop_o, output, 1, registered stop pulse to the tdc.
- busy_o, output, 1, high in RUN or HOLDOFF.
- done_o, output, 1, one-cycle pulse when a finite sequence completes.
- meas_cnt_o, output, COUNT_W, pairs completed since the last accept; wraps.

Behaviour:
- Reset:
  - While rst_n is low at a clk edge: state IDLE, start_o, stop_o, busy_o and done_o are 0, meas_cnt_o is 0, cfg_ready is 0.
  - cfg_ready rises on the first edge after rst_n goes high.
- Accept: a handshake occurs on an edge where cfg_valid && cfg_ready. At that edge:
  - cfg_delay, cfg_width (with 0 mapped to 1) and cfg_count are latched.
  - meas_cnt_o is cleared, the timeline counter t is set to 0, and the state moves to RUN.
- RUN:
  - Timeline counter t is DELAY_W+1 bits and increments every cycle.
  - Registered outputs, sampled relative to the accept edge k:
    - start_o is 1 for exactly W cycles, visible from edge k+1.
    - stop_o is 1 for W cycles, visible from edge k+1+D.
    - D = latched delay, W = latched width.
  - Overlap is legal: D < W keeps both outputs high simultaneously. D = 0 makes start and stop rise on the same edge; this exercises the tdc's stop priority.
  - RUN ends on the cycle where t == D+W-1. Both outputs are 0 on the following edge.
- HOLDOFF:
  - Counts HOLDOFF cycles with both outputs low, then evaluates the pair just completed.
  - meas_cnt_o increments at RUN exit.
  - If cfg_count == 0, or meas_cnt_o != latched count: return to RUN with t = 0. The next start rise follows exactly HOLDOFF cycles after the previous stop fall.
  - Otherwise: go to IDLE and pulse done_o for 1 cycle on the same edge.
- Repetition period is D+W+HOLDOFF cycles.
- Abort:
  - abort is sampled in RUN or HOLDOFF. On the next edge: state IDLE, start_o = 0, stop_o = 0, busy_o = 0, done_o = 0, meas_cnt_o held.
  - A truncated pair is not counted.
  - abort in IDLE has no effect.
  - If abort and cfg_valid are both high in IDLE, the accept proceeds.
- cfg_valid while busy is ignored and not latched; the latched config is stable for the whole sequence.
- Reset mid-sequence: identical to the power-on reset values. No partial pulse may remain high past the reset edge.
- Free-running mode: meas_cnt_o wraps from 2^COUNT_W-1 to 0 with no done_o.

Decomposition:
- Package tdc_pkg:
  - State enum with IDLE, RUN, HOLDOFF.
  - Default localparams for DELAY_W, WIDTH_W, COUNT_W, HOLDOFF.
- One natural sub-module, tdc_pulse_window:
  - Compares t against [lo, lo+W) and registers the result.
  - Instantiated twice: lo = 0 for start, lo = D for stop.
- Top level holds the FSM, the timeline, holdoff and pair counters, and the handshake.

Test Plan:
- Reset: rst_n low for 3 cycles -> all outputs 0; cfg_ready is 0 during reset and 1 one cycle after release.
- Single pair: delay=5, width=2, count=1 accepted at edge k -> start high at edges k+1..k+2, stop high at k+6..k+7, done_o pulses after HOLDOFF=16, meas_cnt_o=1.
- Overlap and zero cases:
  - delay=0, width=3 -> start and stop rise on the same edge and stay high 3 cycles together.
  - width=0 -> 1-cycle pulses.
- Repeat: delay=10, width=1, count=4 -> 4 pairs with period 27 cycles, meas_cnt_o steps 1..4, exactly one done_o, cfg_ready low until IDLE.
- Abort: count=0, abort asserted while stop_o is high -> both outputs 0 on the next edge, meas_cnt_o unchanged, no done_o; cfg_valid offered during the run is ignored.
- Reset mid-run: rst_n low during HOLDOFF of pair 2 -> IDLE, all outputs and meas_cnt_o zero on the same edge.
